// File: rtl/vram_cmd_pkg.sv
// Shared constants and the parser state encoding for the VRAM command sequencer.
package vram_cmd_pkg;

   localparam int DEF_ADDR_W     = 15;
   localparam int DEF_VRAM_DEPTH = 22500;

   localparam logic [7:0] OP_SET_ADDR = 8'hA0;
   localparam logic [7:0] OP_WRITE    = 8'hA1;
   localparam logic [7:0] OP_FILL     = 8'hA2;
   localparam logic [7:0] OP_MODE     = 8'hA3;

   localparam logic [2:0] MODE_DISABLED = 3'd0;
   localparam logic [2:0] MODE_TEXT     = 3'd1;
   localparam logic [2:0] MODE_GFX6     = 3'd2;
   localparam logic [2:0] MODE_GFX4     = 3'd3;
   localparam logic [2:0] MODE_GFX2     = 3'd4;
   localparam logic [2:0] MODE_TILED    = 3'd5;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_WR_LEN,
      S_WR_DATA,
      S_FILL_VAL,
      S_FILL_HI,
      S_FILL_LO,
      S_FILL_RUN,
      S_MODE_ARG
   } state_e;

endpackage

// File: rtl/rx_byte_if.sv
// uart_rx handshake: turns the level-held rx_ready into exactly one
// single-cycle byte_valid per received byte, and can be stalled.
module rx_byte_if (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   input  logic       stall,
   output logic       rx_ack,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   logic ack_q;

   // A byte is taken only while no acknowledge is outstanding, so a held
   // rx_ready cannot be counted twice.
   assign byte_valid = rx_ready & ~ack_q & ~stall;
   assign byte_data  = rx_data;
   assign rx_ack     = ack_q;

   // Acknowledge rises after a consume and drops once rx_ready is seen low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q <= 1'b0;
      end else if (byte_valid) begin
         ack_q <= 1'b1;
      end else if (!rx_ready) begin
         ack_q <= 1'b0;
      end
   end

endmodule

// File: rtl/vram_cmd_ctrl.sv
// Byte-stream command sequencer driving the VRAM user write port.
// Optional inter-byte timeout is enabled with `define VRAM_CMD_TIMEOUT_EN.
module vram_cmd_ctrl
   import vram_cmd_pkg::*;
#(
   parameter int         ADDR_W         = DEF_ADDR_W,
   parameter int         VRAM_DEPTH     = DEF_VRAM_DEPTH,
   parameter logic [2:0] MODE_RESET     = MODE_TEXT,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic              clk10m,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   output logic              rx_ack,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_data,
   output logic              vram_we,
   output logic [2:0]        mode,
   output logic              busy,
   output logic              cmd_err
);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        data_q;
   logic              we_q;
   logic [2:0]        mode_q;
   logic              err_q;
   logic [6:0]        hi_q;
   logic [7:0]        fill_val_q;
   logic [7:0]        fill_hi_q;
   logic [15:0]       fill_cnt_q;
   logic [8:0]        remain_q;

   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              stall;
   logic              timeout_hit;
   logic [ADDR_W-1:0] addr_inc_d;
   logic [14:0]       set_raw_d;
   logic [ADDR_W-1:0] set_addr_d;
   logic [15:0]       fill_cnt_d;

   // Bytes stay queued in uart_rx while a fill is running.
   assign stall = (state_q == S_FILL_RUN);

   rx_byte_if u_rx (
      .clk        (clk10m),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .stall      (stall),
      .rx_ack     (rx_ack),
      .byte_valid (byte_valid),
      .byte_data  (byte_data)
   );

   assign addr_inc_d = (addr_q == ADDR_W'(VRAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
   assign set_raw_d  = {hi_q, byte_data};
   assign set_addr_d = (int'(set_raw_d) >= VRAM_DEPTH) ? '0 : ADDR_W'(set_raw_d);
   assign fill_cnt_d = {fill_hi_q, byte_data};

`ifdef VRAM_CMD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_W-1:0] to_cnt_q;

   assign timeout_hit = (state_q != S_IDLE) && (state_q != S_FILL_RUN) && !byte_valid &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Inter-byte watchdog, only counting while a command is half received.
   always_ff @(posedge clk10m or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else if (byte_valid || timeout_hit || state_q == S_IDLE || state_q == S_FILL_RUN) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`else
   // No watchdog: TIMEOUT_CYCLES is positive, so this is constant low.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   // Parser FSM with registered write port, mode and error outputs.
   always_ff @(posedge clk10m or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
         mode_q     <= MODE_RESET;
         err_q      <= 1'b0;
         hi_q       <= '0;
         fill_val_q <= '0;
         fill_hi_q  <= '0;
         fill_cnt_q <= '0;
         remain_q   <= '0;
      end else begin
         we_q  <= 1'b0;
         err_q <= 1'b0;
         // Post-increment: the address advances the cycle after each write.
         if (we_q) begin
            addr_q <= addr_inc_d;
         end
         if (timeout_hit) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (byte_valid) begin
                     case (byte_data)
                        OP_SET_ADDR: state_q <= S_ADDR_HI;
                        OP_WRITE:    state_q <= S_WR_LEN;
                        OP_FILL:     state_q <= S_FILL_VAL;
                        OP_MODE:     state_q <= S_MODE_ARG;
                        default:     err_q   <= 1'b1;
                     endcase
                  end
               end
               S_ADDR_HI: begin
                  if (byte_valid) begin
                     hi_q    <= byte_data[6:0];
                     state_q <= S_ADDR_LO;
                  end
               end
               S_ADDR_LO: begin
                  if (byte_valid) begin
                     addr_q  <= set_addr_d;
                     state_q <= S_IDLE;
                  end
               end
               S_WR_LEN: begin
                  if (byte_valid) begin
                     remain_q <= {1'b0, byte_data} + 9'd1;
                     state_q  <= S_WR_DATA;
                  end
               end
               S_WR_DATA: begin
                  if (byte_valid) begin
                     we_q     <= 1'b1;
                     data_q   <= byte_data;
                     remain_q <= remain_q - 9'd1;
                     if (remain_q == 9'd1) begin
                        state_q <= S_IDLE;
                     end
                  end
               end
               S_FILL_VAL: begin
                  if (byte_valid) begin
                     fill_val_q <= byte_data;
                     state_q    <= S_FILL_HI;
                  end
               end
               S_FILL_HI: begin
                  if (byte_valid) begin
                     fill_hi_q <= byte_data;
                     state_q   <= S_FILL_LO;
                  end
               end
               S_FILL_LO: begin
                  if (byte_valid) begin
                     if (fill_cnt_d == 16'd0) begin
                        state_q <= S_IDLE;
                     end else begin
                        fill_cnt_q <= fill_cnt_d;
                        we_q       <= 1'b1;
                        data_q     <= fill_val_q;
                        state_q    <= S_FILL_RUN;
                     end
                  end
               end
               S_FILL_RUN: begin
                  // we_q is already high for the current location; keep it
                  // up until the last one has been presented.
                  fill_cnt_q <= fill_cnt_q - 16'd1;
                  if (fill_cnt_q == 16'd1) begin
                     state_q <= S_IDLE;
                  end else begin
                     we_q <= 1'b1;
                  end
               end
               S_MODE_ARG: begin
                  if (byte_valid) begin
                     mode_q  <= byte_data[2:0];
                     state_q <= S_IDLE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign vram_addr = addr_q;
   assign vram_data = data_q;
   assign vram_we   = we_q;
   assign mode      = mode_q;
   assign busy      = (state_q != S_IDLE);
   assign cmd_err   = err_q;

endmodule
